seven_segment_reader: RTL

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

---
 rtl/seven_segment_reader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seven_segment_reader.sv
// Recovers a two-digit decimal number from a multiplexed 7-segment display bus.
// Each digit pattern must hold steady for STABLE_CYCLES clocks before it is decoded.
module seven_segment_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    input  logic       digit,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] value,
    output logic       valid,
    output logic       error
);

    localparam logic [7:0] CAPTURE_AT = 8'(STABLE_CYCLES - 1);

    logic [7:0] sync1_q, sync2_q, prev_q;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] pend_units_q, pend_units_d, pend_tens_q, pend_tens_d;
    logic       have_units_q, have_units_d, have_tens_q, have_tens_d;
    logic [3:0] tens_q, tens_d, units_q, units_d;
    logic [6:0] value_q, value_d;
    logic       valid_q, valid_d, error_q, error_d;
    logic       capture;
    logic       dec_ok;
    logic [3:0] dec_val;

    // prev_q lags sync2_q by one clock, so it is the pattern the counter has been timing
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'd0;
        case (prev_q[6:0])
            7'h3F: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5B: dec_val = 4'd2;
            7'h4F: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6D: dec_val = 4'd5;
            7'h7D: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7F: dec_val = 4'd8;
            7'h6F: dec_val = 4'd9;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        if (sync2_q != prev_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == 8'hFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        // The counter passes CAPTURE_AT only once per stable run, giving one capture
        capture = (cnt_q == CAPTURE_AT);
    end

    always_comb begin
        pend_units_d = pend_units_q;
        pend_tens_d  = pend_tens_q;
        have_units_d = have_units_q;
        have_tens_d  = have_tens_q;
        tens_d       = tens_q;
        units_d      = units_q;
        value_d      = value_q;
        valid_d      = 1'b0;
        error_d      = 1'b0;
        if (capture) begin
            if (!dec_ok) begin
                error_d      = 1'b1;
                have_units_d = 1'b0;
                have_tens_d  = 1'b0;
            end else begin
                if (prev_q[7]) begin
                    pend_tens_d = dec_val;
                    have_tens_d = 1'b1;
                end else begin
                    pend_units_d = dec_val;
                    have_units_d = 1'b1;
                end
                if (have_units_d && have_tens_d) begin
                    tens_d       = pend_tens_d;
                    units_d      = pend_units_d;
                    value_d      = {tens_d, 3'b000} + {2'b00, tens_d, 1'b0} + {3'b000, units_d};
                    valid_d      = 1'b1;
                    have_units_d = 1'b0;
                    have_tens_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            pend_units_q <= '0;
            pend_tens_q  <= '0;
            have_units_q <= 1'b0;
            have_tens_q  <= 1'b0;
            tens_q       <= '0;
            units_q      <= '0;
            value_q      <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            sync1_q      <= {digit, segments};
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            cnt_q        <= cnt_d;
            pend_units_q <= pend_units_d;
            pend_tens_q  <= pend_tens_d;
            have_units_q <= have_units_d;
            have_tens_q  <= have_tens_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;
    assign value = value_q;
    assign valid = valid_q;
    assign error = error_q;

endmodule
